arith_unit_seq: RTL and testbench

- Parametrised, registered arithmetic unit. Successor to the board's 8-bit add/subtract block.
- Adds handshaking, carry-chained ops, a multi-cycle shift-add multiplier, an accumulator and status flags.
- Sits between board switch/UART command decode and display/result logic.
- Operands arrive packed as {B,A}, the same convention as the existing arithmetic blocks.

---
 rtl/arith_unit_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_arith_unit_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_unit_seq.sv
// -----------------------------------------------------------------------------
// arith_unit_seq
//
// Registered arithmetic unit with a valid/ready request handshake. It performs
// add/subtract (with and without chained carry), compare, accumulate/clear, and
// an unsigned shift-add multiply that takes WIDTH steps.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   ab         packed operands {B,A}: A = ab[WIDTH-1:0], B = ab[2*WIDTH-1:WIDTH]
//   op         operation select, sampled when a request is accepted
//   in_valid   request present
//   in_ready   unit can accept a request this cycle
//   result     result (low half of the product for MUL)
//   result_hi  high half of the MUL product, 0 for every other op
//   carry      carry-out for add-class ops, borrow for sub-class ops
//   zero       full result {result_hi,result} is zero (A-B for CMP)
//   ovf        two's-complement overflow for add/sub-class ops, else 0
//   out_valid  one-cycle pulse marking an update of result and flags
//
// Op codes:
//   000 ADD  A+B          001 SUB  A-B
//   010 ADDC A+B+c        011 SUBB A-B-c      (c = internal carry register)
//   100 MUL  A*B unsigned 101 ACC  acc+A
//   110 CLR  acc=0        111 CMP  A-B, flags only
//
// Timing: non-MUL ops are registered on the accepting edge, so out_valid rises
// in the following cycle and a new request may be accepted every cycle. MUL
// holds in_ready low for WIDTH cycles (one shift-add step each); the last step
// writes the product straight into the outputs, so out_valid appears
// WIDTH+1 cycles after the accept, in the DONE cycle, where in_ready is 1 again.
// -----------------------------------------------------------------------------
module arith_unit_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] ab,
    input  logic [2:0]         op,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               carry,
    output logic               zero,
    output logic               ovf,
    output logic               out_valid
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDC = 3'b010;
    localparam logic [2:0] OP_SUBB = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_ACC  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand views of the packed input bus.
    logic [WIDTH-1:0]   a_p0;
    logic [WIDTH-1:0]   b_p0;
    logic               accept_p0;

    // Single-cycle ALU results, registered on accept.
    logic [WIDTH:0]     wide_p0;
    logic               ovf_p0;
    logic               keep_res_p0;
    logic [WIDTH-1:0]   acc_nxt_p0;

    // Architectural state kept across requests.
    logic [WIDTH-1:0]   acc;
    logic               c_reg;

    // Multiplier working registers.
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     step_add;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               mul_last;

    // Overflow for x + y (+cin): operands agree in sign, sum sign differs.
    function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Overflow for x - y (-bin): operands differ in sign, result sign
    // differs from the minuend.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] s);
        return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign a_p0      = ab[WIDTH-1:0];
    assign b_p0      = ab[2*WIDTH-1:WIDTH];
    assign in_ready  = (state != MULT);
    assign accept_p0 = in_valid && in_ready;

    // ---- stage p0: combinational ALU on the incoming request ----
    always_comb begin
        wide_p0     = '0;
        ovf_p0      = 1'b0;
        keep_res_p0 = 1'b0;
        acc_nxt_p0  = acc;
        case (op)
            OP_ADD: begin
                wide_p0 = {1'b0, a_p0} + {1'b0, b_p0};
                ovf_p0  = add_ovf(a_p0, b_p0, wide_p0[WIDTH-1:0]);
            end
            OP_SUB: begin
                wide_p0 = {1'b0, a_p0} - {1'b0, b_p0};
                ovf_p0  = sub_ovf(a_p0, b_p0, wide_p0[WIDTH-1:0]);
            end
            OP_ADDC: begin
                wide_p0 = {1'b0, a_p0} + {1'b0, b_p0} + {{WIDTH{1'b0}}, c_reg};
                ovf_p0  = add_ovf(a_p0, b_p0, wide_p0[WIDTH-1:0]);
            end
            OP_SUBB: begin
                // Bit WIDTH of the (WIDTH+1)-bit difference is the borrow.
                wide_p0 = {1'b0, a_p0} - {1'b0, b_p0} - {{WIDTH{1'b0}}, c_reg};
                ovf_p0  = sub_ovf(a_p0, b_p0, wide_p0[WIDTH-1:0]);
            end
            OP_ACC: begin
                wide_p0    = {1'b0, acc} + {1'b0, a_p0};
                ovf_p0     = add_ovf(acc, a_p0, wide_p0[WIDTH-1:0]);
                acc_nxt_p0 = wide_p0[WIDTH-1:0];
            end
            OP_CLR: begin
                acc_nxt_p0 = '0;
            end
            OP_CMP: begin
                wide_p0     = {1'b0, a_p0} - {1'b0, b_p0};
                ovf_p0      = sub_ovf(a_p0, b_p0, wide_p0[WIDTH-1:0]);
                keep_res_p0 = 1'b1;
            end
            default: begin
                // MUL goes through the multi-cycle path.
                wide_p0 = '0;
            end
        endcase
    end

    // ---- multiplier step: add multiplicand when multiplier LSB is set, ----
    // ---- then shift the partial product right by one                   ----
    always_comb begin
        step_add = mplier[0] ? {1'b0, mcand} : '0;
        step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + step_add;
        prod_nxt = {step_sum, prod[WIDTH-1:1]};
        mul_last = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE accepts requests exactly like IDLE; it only marks the cycle that
    // carries the multiply result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (in_valid && (op == OP_MUL)) begin
                    state_nxt = MULT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MULT: begin
                if (mul_last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p1: registered outputs and architectural state ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            c_reg     <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == MULT) begin
                prod   <= prod_nxt;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_ONE;
                if (mul_last) begin
                    result    <= prod_nxt[WIDTH-1:0];
                    result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
                    carry     <= 1'b0;
                    ovf       <= 1'b0;
                    zero      <= (prod_nxt == '0);
                    out_valid <= 1'b1;
                end
            end else if (accept_p0) begin
                if (op == OP_MUL) begin
                    mcand  <= a_p0;
                    mplier <= b_p0;
                    prod   <= '0;
                    cnt    <= '0;
                end else begin
                    if (!keep_res_p0) begin
                        result    <= wide_p0[WIDTH-1:0];
                        result_hi <= '0;
                    end
                    carry     <= wide_p0[WIDTH];
                    zero      <= (wide_p0[WIDTH-1:0] == '0);
                    ovf       <= ovf_p0;
                    out_valid <= 1'b1;
                    c_reg     <= wide_p0[WIDTH];
                    acc       <= acc_nxt_p0;
                end
            end
        end
    end

endmodule

// File: tb/tb_arith_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_arith_unit_seq
//
// Self-checking bench for arith_unit_seq (WIDTH=8). A behavioural model built
// on integer arithmetic predicts result, flags, accumulator and carry chain;
// directed sequences cover the named scenarios, then a randomized run mixes
// all ops with boundary operands.
// -----------------------------------------------------------------------------
module tb_arith_unit_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [2*WIDTH-1:0] ab = '0;
    logic [2:0]         op = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   result_hi;
    logic               carry;
    logic               zero;
    logic               ovf;
    logic               out_valid;

    arith_unit_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ab        (ab),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state and expectations for the most recent request.
    int m_acc = 0;
    int m_c   = 0;
    int m_res = 0;
    int m_hi  = 0;
    int e_carry, e_zero, e_ovf;

    int edge_vals[6] = '{0, 1, 8'h7F, 8'h80, 8'hFE, 8'hFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int out_of_range(input int s);
        return ((s > 127) || (s < -128)) ? 1 : 0;
    endfunction

    // Predicts the outcome of one accepted request and advances model state.
    task automatic model(input int o, input int a, input int b);
        int u, s, p;
        case (o)
            0, 2: begin // ADD, ADDC
                u = a + b + ((o == 2) ? m_c : 0);
                s = sgn(a) + sgn(b) + ((o == 2) ? m_c : 0);
                m_res = u % 256; m_hi = 0;
                e_carry = (u > 255) ? 1 : 0;
                e_ovf = out_of_range(s);
                e_zero = (m_res == 0) ? 1 : 0;
                m_c = e_carry;
            end
            1, 3: begin // SUB, SUBB
                u = a - b - ((o == 3) ? m_c : 0);
                s = sgn(a) - sgn(b) - ((o == 3) ? m_c : 0);
                m_res = u & 255; m_hi = 0;
                e_carry = (u < 0) ? 1 : 0;
                e_ovf = out_of_range(s);
                e_zero = (m_res == 0) ? 1 : 0;
                m_c = e_carry;
            end
            4: begin // MUL: carry register untouched
                p = a * b;
                m_res = p % 256; m_hi = p / 256;
                e_carry = 0; e_ovf = 0;
                e_zero = (p == 0) ? 1 : 0;
            end
            5: begin // ACC
                u = m_acc + a;
                s = sgn(m_acc) + sgn(a);
                m_acc = u % 256;
                m_res = m_acc; m_hi = 0;
                e_carry = (u > 255) ? 1 : 0;
                e_ovf = out_of_range(s);
                e_zero = (m_res == 0) ? 1 : 0;
                m_c = e_carry;
            end
            6: begin // CLR
                m_acc = 0; m_res = 0; m_hi = 0;
                e_carry = 0; e_ovf = 0; e_zero = 1;
                m_c = 0;
            end
            default: begin // CMP: result registers keep their value
                u = a - b;
                s = sgn(a) - sgn(b);
                e_carry = (u < 0) ? 1 : 0;
                e_ovf = out_of_range(s);
                e_zero = ((u & 255) == 0) ? 1 : 0;
                m_c = e_carry;
            end
        endcase
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".result"}, 32'(result), 32'(m_res));
        chk({tag, ".result_hi"}, 32'(result_hi), 32'(m_hi));
        chk({tag, ".carry"}, 32'(carry), 32'(e_carry));
        chk({tag, ".zero"}, 32'(zero), 32'(e_zero));
        chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
    endtask

    // One request: wait for ready, present it for one cycle, check latency,
    // outputs, then one idle cycle confirming the pulse ends and values hold.
    task automatic do_op(input int o, input int a, input int b, input string tag);
        int k;
        int busy;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".ready_wait"}, 32'(in_ready), 32'd1);
        op = 3'(o);
        ab = {8'(b), 8'(a)};
        in_valid = 1'b1;
        model(o, a, b);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        if (o == 4) begin
            busy = 0;
            while (!out_valid && k < 40) begin
                if (!in_ready) busy++;
                // Junk requests while busy must be ignored.
                in_valid = 1'($urandom);
                ab = 16'($urandom);
                op = 3'($urandom);
                @(negedge clk);
                k++;
            end
            in_valid = 1'b0;
            chk({tag, ".mul_latency"}, 32'(k), 32'(WIDTH + 1));
            chk({tag, ".mul_busy"}, 32'(busy), 32'(WIDTH));
            chk({tag, ".ready_at_done"}, 32'(in_ready), 32'd1);
        end
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check_outs(tag);
        @(negedge clk);
        chk({tag, ".pulse_end"}, 32'(out_valid), 32'd0);
        chk({tag, ".hold"}, 32'({result_hi, result}), 32'(m_hi * 256 + m_res));
    endtask

    // Non-MUL requests on consecutive cycles.
    task automatic burst(input int n);
        int o, a, b;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            o = $urandom_range(0, 7);
            if (o == 4) o = 5;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            op = 3'(o);
            ab = {8'(b), 8'(a)};
            in_valid = 1'b1;
            model(o, a, b);
            @(negedge clk);
            chk("b2b.out_valid", 32'(out_valid), 32'd1);
            chk("b2b.in_ready", 32'(in_ready), 32'd1);
            check_outs("b2b");
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b.pulse_end", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        int o, a, b;

        // Reset state.
        #2;
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.result_hi", 32'(result_hi), 32'd0);
        chk("rst.flags", 32'({carry, zero, ovf}), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        #10 rst = 1'b1;

        // Basic add/sub and overflow.
        do_op(0, 3, 4, "add_3_4");
        chk("add_3_4.const", 32'(result), 32'd7);
        do_op(1, 3, 4, "sub_3_4");
        chk("sub_3_4.const", 32'({carry, result}), 32'h1FF);
        do_op(0, 8'h7F, 8'h01, "add_ovf");
        chk("add_ovf.const", 32'({ovf, result}), 32'h180);

        // Carry chain.
        do_op(0, 8'hFF, 8'h01, "add_ff_1");
        chk("add_ff_1.const", 32'({carry, zero, result}), 32'h300);
        do_op(2, 0, 0, "addc_0_0");
        chk("addc_0_0.const", 32'({carry, result}), 32'h001);
        do_op(3, 0, 0, "subb_after_nc");

        // Multiply.
        do_op(4, 9, 3, "mul_9_3");
        chk("mul_9_3.const", 32'({result_hi, result}), 32'd27);
        do_op(4, 8'hFF, 8'hFF, "mul_ff_ff");
        chk("mul_ff_ff.const", 32'({result_hi, result}), 32'hFE01);
        do_op(2, 8'hFF, 0, "addc_after_mul");

        // Accumulator.
        do_op(6, 0, 0, "clr");
        do_op(5, 5, 0, "acc_5");
        do_op(5, 8, 0, "acc_8");
        do_op(5, 8'hF5, 0, "acc_f5");
        chk("acc_f5.const", 32'({carry, result}), 32'h102);

        // Compare keeps result.
        do_op(7, 8'h40, 8'h40, "cmp_eq");
        do_op(7, 8'h80, 8'h01, "cmp_ovf");

        // CLR immediately followed by ACC.
        @(negedge clk);
        op = 3'd6; ab = 16'h0000; in_valid = 1'b1; model(6, 0, 0);
        @(negedge clk);
        op = 3'd5; ab = 16'h0009; model(5, 9, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("clr_acc.out_valid", 32'(out_valid), 32'd1);
        check_outs("clr_acc");

        burst(6);

        // Reset in the middle of a multiply.
        @(negedge clk);
        op = 3'd4; ab = {8'd3, 8'd9}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst.result", 32'({result_hi, result}), 32'd0);
        chk("midrst.flags", 32'({carry, zero, ovf, out_valid}), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_acc = 0; m_c = 0; m_res = 0; m_hi = 0;
        seen = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst.no_valid", 32'(seen), 32'd0);
        do_op(0, 2, 6, "post_rst_add");
        chk("post_rst_add.const", 32'(result), 32'd8);
        do_op(5, 4, 0, "post_rst_acc");
        do_op(2, 1, 1, "post_rst_addc");

        // Randomized mix with boundary operands.
        for (int i = 0; i < 250; i++) begin
            o = $urandom_range(0, 7);
            if (o == 4 && $urandom_range(0, 1) == 0) o = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom_range(0, 255);
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom_range(0, 255);
            do_op(o, a, b, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
